stream_monitor: RTL and testbench
=================================

Name: stream_monitor

Overview:
Passive monitor on a valid/ready stream that feeds one side (a_en/a or b_en/b) of the in-order scoreboard.
- Captures each accepted beat.
- Packs PACK consecutive beats into one wide word; `last` flushes a partial word early.
- Emits that word as a single-cycle enable/data pulse to the scoreboard.
- Checks valid/ready protocol rules and keeps running counts of beats, words and errors.

Parameters:
BITS, 8, width of one stream beat (must be >= 1)
PACK, 1, beats per emitted word (must be >= 1); output width = BITS*PACK
TIMEOUT, 1000, max consecutive stall cycles before a stall error (used only with the optional feature)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
valid  input  1  stream valid
ready  input  1  stream ready
data  input  BITS  stream data
last  input  1  end-of-packet marker; flushes a partial word
mon_en  output  1  one-cycle pulse: mon_data holds a completed word (to scoreboard a_en/b_en)
mon_data  output  BITS*PACK  packed word; beat 0 in LSBs
beats  output  int  accepted-beat count
words  output  int  emitted-word count
protocol_errors  output  int  protocol violation count

Behaviour:
- Reset (async, rst_n low):
  - mon_en=0, mon_data=0, beats=0, words=0, protocol_errors=0.
  - Pack counter=0, pack buffer=0, stall history cleared.
  - Asserting reset mid-word discards the partial word; nothing is emitted for it.
- Accept: a beat is accepted on a posedge where valid && ready.
  - beats increments by 1 per accepted beat.
- Packing:
  - Pack counter idx runs 0..PACK-1.
  - An accepted beat is written to buffer slice [idx*BITS +: BITS].
- Emission, registered with 1-cycle latency:
  - Trigger: an accepted beat with idx==PACK-1, or with last=1.
  - The cycle after the accepting edge: mon_en=1 and mon_data = completed buffer (including the new beat).
  - Slices not written in this word read 0.
  - On that same edge: idx returns to 0, buffer clears, words increments.
- mon_en is high exactly one cycle per word.
  - Back-to-back emission is allowed on consecutive cycles (e.g. PACK=1 at full throughput).
  - mon_data holds its last value while mon_en=0.
- last is sampled only on accepted beats; last on an idle or stalled cycle is ignored.
- PACK=1: every accepted beat emits; last has no effect.
- Protocol checks (registered history of previous cycle):
  - Stall = valid && !ready.
  - If the previous cycle stalled and the current cycle has valid=0: protocol_errors increments; $error "valid dropped during stall".
  - If the previous cycle stalled and the current cycle has valid=1 with data or last differing from the previous cycle: protocol_errors increments; $error "data changed during stall".
  - At most one increment per cycle; the drop check takes precedence.
  - History is cleared by reset, so no check fires on the first cycle after reset.
- Counters wrap modulo 2^32 and carry no saturation.
- The block is purely observational and drives no stream signals.

Optional Feature:
Macro: STREAM_MONITOR_TIMEOUT_EN
- Defined:
  - A stall counter increments on each stall cycle and resets to 0 on any cycle that is not a stall.
  - When the counter reaches TIMEOUT: protocol_errors increments once; $error "stall timeout".
  - No further increments occur until the counter resets.
  - The counter resets to 0 under rst_n.
- Not defined: no stall counter exists, TIMEOUT is unused, and behaviour is otherwise identical.

Test Plan:
1. BITS=8, PACK=1: beats 0x11, 0x22, 0x33 accepted on consecutive cycles -> mon_en high 3 consecutive cycles starting one cycle after the first accept; mon_data 0x11, 0x22, 0x33; beats=3, words=3.
2. BITS=8, PACK=4: beats 0xA0, 0xA1, 0xA2, 0xA3 with ready toggling every cycle -> one mon_en pulse, mon_data=0xA3A2A1A0; words=1, protocol_errors=0.
3. BITS=8, PACK=4: beats 0x01, 0x02 then 0x03 with last=1 -> mon_data=0x00030201, words=1; next four beats 0x10..0x13 -> mon_data=0x13121110.
4. Protocol: valid=1, ready=0, data=0x55 for 2 cycles, then data=0x56 with ready=0 -> protocol_errors=1; later stall followed by valid=0 -> protocol_errors=2.
5. Reset mid-word: PACK=4, accept 2 beats, pulse rst_n low for 1 cycle, then accept 0xB0..0xB3 -> single word 0xB3B2B1B0; beats=4, words=1.
6. STREAM_MONITOR_TIMEOUT_EN, TIMEOUT=5: hold valid=1, ready=0 with stable data for 8 cycles -> protocol_errors=1, exactly one $error; without the macro -> protocol_errors=0.

Source files
------------

// File: rtl/stream_monitor.sv
// Passive valid/ready monitor: packs PACK beats per word, counts beats/words/protocol errors; optional STREAM_MONITOR_TIMEOUT_EN stall timeout.
// Latency: word appears on mon_en/mon_data 1 cycle after the completing accept; never backpressures (observe-only).
module stream_monitor #(
  parameter int BITS      = 8,
  parameter int PACK      = 1,
  parameter int TIMEOUT   = 1000,
  parameter bit REPORT_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid,
  input  logic                 ready,
  input  logic [BITS-1:0]      data,
  input  logic                 last,
  output logic                 mon_en,
  output logic [BITS*PACK-1:0] mon_data,
  output int                   beats,
  output int                   words,
  output int                   protocol_errors
);

  localparam int W    = BITS * PACK;
  localparam int IDXW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(PACK - 1);

  if (BITS < 1 || PACK < 1 || TIMEOUT < 1) begin : g_param_check
    $error("stream_monitor: BITS, PACK and TIMEOUT must all be >= 1");
  end

  logic [IDXW-1:0] idx;
  logic [W-1:0]    pack_buf;
  logic [W-1:0]    buf_nxt;
  logic            accept;
  logic            emit;
  logic            stall;
  logic            prev_stall;
  logic            prev_last;
  logic [BITS-1:0] prev_data;
  logic            drop_err;
  logic            chg_err;
  logic            to_err;
  logic            err_inc;

  assign accept = valid && ready;
  assign emit   = accept && ((idx == IDX_LAST) || last);
  assign stall  = valid && !ready;

  always_comb begin
    buf_nxt = pack_buf;
    buf_nxt[int'(idx)*BITS +: BITS] = data;
  end

  // History is only meaningful after a stalled cycle; drop wins over change.
  assign drop_err = prev_stall && !valid;
  assign chg_err  = prev_stall && valid && ((data != prev_data) || (last != prev_last));

`ifdef STREAM_MONITOR_TIMEOUT_EN
  int stall_cnt;

  // Counter saturates at TIMEOUT so a long stall reports only once.
  assign to_err = stall && (stall_cnt == TIMEOUT - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 0;
    end else if (!stall) begin
      stall_cnt <= 0;
    end else if (stall_cnt != TIMEOUT) begin
      stall_cnt <= stall_cnt + 1;
    end
  end
`else
  assign to_err = 1'b0;
`endif

  assign err_inc = drop_err || chg_err || to_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx             <= '0;
      pack_buf        <= '0;
      mon_en          <= 1'b0;
      mon_data        <= '0;
      beats           <= 0;
      words           <= 0;
      protocol_errors <= 0;
      prev_stall      <= 1'b0;
      prev_last       <= 1'b0;
      prev_data       <= '0;
    end else begin
      mon_en     <= emit;
      prev_stall <= stall;
      prev_last  <= last;
      prev_data  <= data;
      if (accept) begin
        beats <= beats + 1;
        if (emit) begin
          mon_data <= buf_nxt;
          pack_buf <= '0;
          idx      <= '0;
          words    <= words + 1;
        end else begin
          pack_buf <= buf_nxt;
          idx      <= idx + 1'b1;
        end
      end
      if (err_inc) begin
        protocol_errors <= protocol_errors + 1;
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (REPORT_EN && rst_n) begin
      if (drop_err) begin
        $error("valid dropped during stall");
      end else if (chg_err) begin
        $error("data changed during stall");
      end
      if (to_err) begin
        $error("stall timeout");
      end
    end
  end
`endif

endmodule

// File: tb/tb_stream_monitor.sv
// Bench for stream_monitor: PACK=1 and PACK=4 instances observe one shared stream.
module tb_stream_monitor;

  localparam int TO = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic       ready = 1'b0;
  logic       last  = 1'b0;
  logic [7:0] data  = 8'h00;

  logic        m1_en;
  logic [7:0]  m1_data;
  int          b1, w1, e1;
  logic        m4_en;
  logic [31:0] m4_data;
  int          b4, w4, e4;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef STREAM_MONITOR_TIMEOUT_EN
  localparam int EXP_TO = 1;
`else
  localparam int EXP_TO = 0;
`endif

  stream_monitor #(.BITS(8), .PACK(1), .TIMEOUT(TO), .REPORT_EN(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .valid(valid), .ready(ready), .data(data), .last(last),
    .mon_en(m1_en), .mon_data(m1_data), .beats(b1), .words(w1), .protocol_errors(e1)
  );

  stream_monitor #(.BITS(8), .PACK(4), .TIMEOUT(TO), .REPORT_EN(1'b0)) dut4 (
    .clk(clk), .rst_n(rst_n), .valid(valid), .ready(ready), .data(data), .last(last),
    .mon_en(m4_en), .mon_data(m4_data), .beats(b4), .words(w4), .protocol_errors(e4)
  );

  // Reference model: beats collected in a queue, a word is the queue packed LSB-first.
  logic [7:0]  pend[$];
  bit          x_en1, x_en4, p_stall, p_last, m_bad;
  logic [7:0]  x_d1, p_data;
  logic [31:0] x_d4;
  int          x_beats, x_w1, x_w4, x_err, run;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend.delete();
      x_en1 = 0; x_en4 = 0; x_d1 = 0; x_d4 = 0;
      x_beats = 0; x_w1 = 0; x_w4 = 0; x_err = 0; run = 0;
      p_stall = 0; p_last = 0; p_data = 0;
    end else begin
      x_en1 = 0; x_en4 = 0; m_bad = 0;
      if (valid && ready) begin
        x_beats++;
        x_en1 = 1; x_d1 = data; x_w1++;
        pend.push_back(data);
        if (pend.size() == 4 || last) begin
          x_d4 = 0;
          foreach (pend[i]) x_d4 |= 32'(pend[i]) << (8 * i);
          x_en4 = 1; x_w4++;
          pend.delete();
        end
      end
      if (p_stall && (!valid || data !== p_data || last !== p_last)) m_bad = 1;
`ifdef STREAM_MONITOR_TIMEOUT_EN
      if (valid && !ready) begin
        run++;
        if (run == TO) m_bad = 1;
      end else begin
        run = 0;
      end
`endif
      if (m_bad) x_err++;
      p_stall = valid && !ready; p_data = data; p_last = last;
    end
  end

  task automatic drive(input bit v, input bit r, input logic [7:0] d, input bit l);
    valid = v; ready = r; data = d; last = l;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    valid = 0; ready = 0; data = 0; last = 0;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_reset;
    do_reset();
    n_chk++;
    if ({m1_en, m1_data, b1, w1, e1} !== '0) begin
      n_fail++; $display("FAIL reset_pack1 en=%b data=%h beats=%0d words=%0d err=%0d expected all 0", m1_en, m1_data, b1, w1, e1);
    end
    n_chk++;
    if ({m4_en, m4_data, b4, w4, e4} !== '0) begin
      n_fail++; $display("FAIL reset_pack4 en=%b data=%h beats=%0d words=%0d err=%0d expected all 0", m4_en, m4_data, b4, w4, e4);
    end
  endtask

  task automatic test_pack1;
    logic [7:0] v[3];
    v[0] = 8'h11; v[1] = 8'h22; v[2] = 8'h33;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, v[i], 0);
      n_chk++;
      if (m1_en !== 1'b1 || m1_data !== v[i]) begin
        n_fail++; $display("FAIL pack1_beat%0d en=%b data=%h expected 1/%h", i, m1_en, m1_data, v[i]);
      end
    end
    drive(0, 0, 8'h00, 0);
    n_chk++;
    if (m1_en !== 1'b0 || m1_data !== 8'h33 || b1 !== 3 || w1 !== 3) begin
      n_fail++; $display("FAIL pack1_idle en=%b data=%h beats=%0d words=%0d expected 0/33/3/3", m1_en, m1_data, b1, w1);
    end
  endtask

  task automatic test_pack4_toggle;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 8'hA0 + 8'(i), 0);
      drive(1, 1, 8'hA0 + 8'(i), 0);
      if (i < 3) begin
        n_chk++;
        if (m4_en !== 1'b0) begin
          n_fail++; $display("FAIL toggle_early_en beat%0d en=%b expected 0", i, m4_en);
        end
      end
    end
    n_chk++;
    if (m4_en !== 1'b1 || m4_data !== 32'hA3A2A1A0) begin
      n_fail++; $display("FAIL toggle_word en=%b data=%h expected 1/a3a2a1a0", m4_en, m4_data);
    end
    drive(0, 0, 8'h00, 0);
    n_chk++;
    if (m4_en !== 1'b0 || w4 !== 1 || e4 !== 0 || b4 !== 4) begin
      n_fail++; $display("FAIL toggle_counts en=%b words=%0d err=%0d beats=%0d expected 0/1/0/4", m4_en, w4, e4, b4);
    end
  endtask

  task automatic test_last_flush;
    do_reset();
    drive(1, 1, 8'h01, 0);
    drive(1, 1, 8'h02, 0);
    drive(1, 1, 8'h03, 1);
    n_chk++;
    if (m4_en !== 1'b1 || m4_data !== 32'h00030201 || w4 !== 1) begin
      n_fail++; $display("FAIL last_flush en=%b data=%h words=%0d expected 1/00030201/1", m4_en, m4_data, w4);
    end
    for (int i = 0; i < 4; i++) drive(1, 1, 8'h10 + 8'(i), 0);
    n_chk++;
    if (m4_en !== 1'b1 || m4_data !== 32'h13121110 || w4 !== 2) begin
      n_fail++; $display("FAIL after_flush en=%b data=%h words=%0d expected 1/13121110/2", m4_en, m4_data, w4);
    end
    drive(0, 0, 8'h00, 1);
    n_chk++;
    if (m4_en !== 1'b0 || m4_data !== 32'h13121110 || w4 !== 2) begin
      n_fail++; $display("FAIL idle_last_ignored en=%b data=%h words=%0d expected 0/13121110/2", m4_en, m4_data, w4);
    end
  endtask

  task automatic test_protocol;
    do_reset();
    drive(1, 0, 8'h55, 0);
    drive(1, 0, 8'h55, 0);
    n_chk++;
    if (e1 !== 0) begin
      n_fail++; $display("FAIL stable_stall err=%0d expected 0", e1);
    end
    drive(1, 0, 8'h56, 0);
    n_chk++;
    if (e1 !== 1 || e4 !== 1) begin
      n_fail++; $display("FAIL data_change err1=%0d err4=%0d expected 1/1", e1, e4);
    end
    drive(1, 1, 8'h56, 0);
    drive(1, 0, 8'h77, 0);
    drive(0, 0, 8'h00, 0);
    n_chk++;
    if (e1 !== 2 || e4 !== 2) begin
      n_fail++; $display("FAIL valid_drop err1=%0d err4=%0d expected 2/2", e1, e4);
    end
    drive(0, 0, 8'h00, 0);
    n_chk++;
    if (e1 !== 2) begin
      n_fail++; $display("FAIL after_drop err=%0d expected 2", e1);
    end
  endtask

  task automatic test_reset_mid_word;
    do_reset();
    drive(1, 1, 8'hC0, 0);
    drive(1, 1, 8'hC1, 0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 8'hB0 + 8'(i), 0);
      if (i < 3) begin
        n_chk++;
        if (m4_en !== 1'b0) begin
          n_fail++; $display("FAIL midreset_early_en beat%0d en=%b expected 0", i, m4_en);
        end
      end
    end
    n_chk++;
    if (m4_en !== 1'b1 || m4_data !== 32'hB3B2B1B0 || b4 !== 4 || w4 !== 1) begin
      n_fail++; $display("FAIL midreset_word en=%b data=%h beats=%0d words=%0d expected 1/b3b2b1b0/4/1", m4_en, m4_data, b4, w4);
    end
  endtask

  task automatic test_timeout;
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      drive(1, 0, 8'h5A, 0);
      if (i == 4) begin
        n_chk++;
        if (e1 !== 0) begin
          n_fail++; $display("FAIL timeout_before err=%0d expected 0", e1);
        end
      end
      if (i == 5) begin
        n_chk++;
        if (e1 !== EXP_TO) begin
          n_fail++; $display("FAIL timeout_at err=%0d expected %0d", e1, EXP_TO);
        end
      end
    end
    drive(1, 1, 8'h5A, 0);
    n_chk++;
    if (e1 !== EXP_TO || e4 !== EXP_TO) begin
      n_fail++; $display("FAIL timeout_once err1=%0d err4=%0d expected %0d", e1, e4, EXP_TO);
    end
  endtask

  task automatic test_random;
    bit hold;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        do_reset();
      end else begin
        hold = valid && !ready && ($urandom_range(0, 9) != 0);
        if (hold) begin
          drive(1, $urandom_range(0, 1) == 1, data, last);
        end else begin
          drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 4) == 0);
        end
      end
      n_chk++;
      if ({m1_en, m1_data, b1, w1, e1} !== {x_en1, x_d1, x_beats, x_w1, x_err}) begin
        n_fail++; $display("FAIL rand_pack1 cyc%0d en=%b data=%h b=%0d w=%0d e=%0d expected %b/%h/%0d/%0d/%0d",
                           i, m1_en, m1_data, b1, w1, e1, x_en1, x_d1, x_beats, x_w1, x_err);
      end
      n_chk++;
      if ({m4_en, m4_data, b4, w4, e4} !== {x_en4, x_d4, x_beats, x_w4, x_err}) begin
        n_fail++; $display("FAIL rand_pack4 cyc%0d en=%b data=%h b=%0d w=%0d e=%0d expected %b/%h/%0d/%0d/%0d",
                           i, m4_en, m4_data, b4, w4, e4, x_en4, x_d4, x_beats, x_w4, x_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pack1();
    test_pack4_toggle();
    test_last_flush();
    test_protocol();
    test_reset_mid_word();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
